// File: rtl/chrom_eval_sequencer.sv
// chrom_eval_sequencer
//
// Sequences one fitness evaluation of a chromosome. After a start request
// from the HPS, it fetches N sample words and the matching expected-output
// words from two RAMs. It applies each sample to the genetic circuit and waits
// for the circuit outputs. Masked output mismatches are counted per output in
// saturating counters, which are reported back together with a done flag.
//
// Handshake notes:
//   start_i          : level from the HPS; only a rising edge seen in IDLE
//                      starts a run.
//   done_o/done_ack_i: done_o stays high until done_ack_i=1 and start_i=0 in
//                      the same cycle.
//   eval_in_valid_o  : one-cycle strobe; eval_in_o holds until the next strobe.
//   eval_out_valid_i : one-cycle strobe; honoured only in APPLY or WAIT_OUT.
//
// Ports:
//   clk_clk, reset_reset_n             clock, async active-low reset
//   start_i, seq_count_i, valid_mask_i run setup (sampled on the start edge)
//   done_ack_i                         HPS acknowledge of done
//   ready_o, done_o, timeout_o         status
//   sample_index_o                     current / last sample index
//   mem_*  / cmem_*                    sample RAM / correct RAM read ports
//   eval_in_o, eval_in_valid_o         sample word to the circuit
//   eval_out_i, eval_out_valid_i       circuit outputs
//   error_sum_o                        counter j at [j*ERR_W +: ERR_W]
//   dbg_state_o                        current FSM state encoding
module chrom_eval_sequencer #(
  parameter int NUM_OUT = 8,
  parameter int ERR_W   = 32,
  parameter int ADDR_W  = 15,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     start_i,
  input  logic [31:0]              seq_count_i,
  input  logic [NUM_OUT-1:0]       valid_mask_i,
  input  logic                     done_ack_i,
  output logic                     ready_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic [31:0]              sample_index_o,
  output logic [ADDR_W-1:0]        mem_address_o,
  output logic                     mem_chipselect_o,
  output logic                     mem_clken_o,
  input  logic [31:0]              mem_readdata_i,
  output logic [ADDR_W-1:0]        cmem_address_o,
  output logic                     cmem_chipselect_o,
  output logic                     cmem_clken_o,
  input  logic [31:0]              cmem_readdata_i,
  output logic [31:0]              eval_in_o,
  output logic                     eval_in_valid_o,
  input  logic [NUM_OUT-1:0]       eval_out_i,
  input  logic                     eval_out_valid_i,
  output logic [NUM_OUT*ERR_W-1:0] error_sum_o,
  output logic [2:0]               dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_APPLY    = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_ACCUM    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam logic [31:0] MAX_N = 32'd1 << ADDR_W;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_start_d;
  logic [31:0]              r_n;
  logic [31:0]              r_index;
  logic [NUM_OUT-1:0]       r_mask;
  logic [NUM_OUT-1:0]       r_exp;
  logic [NUM_OUT-1:0]       r_out;
  logic [31:0]              r_sample;
  logic [NUM_OUT*ERR_W-1:0] r_err;
  logic                     r_timeout;
  logic [7:0]               r_lat;
  logic [TW-1:0]            r_tcnt;

  logic        w_start_edge;
  logic        w_last_rd;
  logic        w_timeout_hit;
  logic        w_last_sample;
  logic [31:0] w_n_new;
  logic        w_unused;

  assign w_start_edge  = start_i & ~r_start_d;
  assign w_last_rd     = (r_lat == 8'(MEM_LAT - 1));
  assign w_timeout_hit = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_last_sample = (r_index == (r_n - 32'd1));
  // Run length is clamped to the RAM depth.
  assign w_n_new       = (seq_count_i > MAX_N) ? MAX_N : seq_count_i;
  // Only the low NUM_OUT bits of an expected word map to circuit outputs.
  assign w_unused      = ^cmem_readdata_i[31:NUM_OUT];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    ready_o           = 1'b0;
    done_o            = 1'b0;
    mem_chipselect_o  = 1'b0;
    eval_in_valid_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_start_edge) w_next = (w_n_new == 32'd0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        mem_chipselect_o = 1'b1;
        w_next           = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        mem_chipselect_o = 1'b1;
        if (w_last_rd) w_next = S_APPLY;
      end
      S_APPLY: begin
        eval_in_valid_o = 1'b1;
        // A circuit with zero latency answers in the APPLY cycle itself.
        w_next = eval_out_valid_i ? S_ACCUM : S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (eval_out_valid_i)   w_next = S_ACCUM;
        else if (w_timeout_hit) w_next = S_DONE;
      end
      S_ACCUM: w_next = w_last_sample ? S_DONE : S_FETCH;
      S_DONE: begin
        done_o = 1'b1;
        // start_i must be low so that the next run needs a fresh edge.
        if (done_ack_i && !start_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_start_d <= 1'b0;
      r_n       <= '0;
      r_index   <= '0;
      r_mask    <= '0;
      r_exp     <= '0;
      r_out     <= '0;
      r_sample  <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
      r_lat     <= '0;
      r_tcnt    <= '0;
    end else begin
      r_start_d <= start_i;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_n       <= w_n_new;
            r_mask    <= valid_mask_i;
            r_err     <= '0;
            r_index   <= '0;
            r_timeout <= 1'b0;
          end
        end
        S_FETCH: r_lat <= '0;
        S_WAIT_RD: begin
          r_lat <= r_lat + 8'd1;
          if (w_last_rd) begin
            r_sample <= mem_readdata_i;
            r_exp    <= cmem_readdata_i[NUM_OUT-1:0];
          end
        end
        S_APPLY: begin
          r_tcnt <= '0;
          if (eval_out_valid_i) r_out <= eval_out_i;
        end
        S_WAIT_OUT: begin
          if (eval_out_valid_i) begin
            r_out <= eval_out_i;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
            if (w_timeout_hit) r_timeout <= 1'b1;
          end
        end
        S_ACCUM: begin
          for (int j = 0; j < NUM_OUT; j++) begin
            if (r_mask[j] && (r_out[j] != r_exp[j]) &&
                (r_err[j*ERR_W +: ERR_W] != {ERR_W{1'b1}}))
              r_err[j*ERR_W +: ERR_W] <= r_err[j*ERR_W +: ERR_W] + ERR_W'(1);
          end
          // The index stays on the last sample so that it reports that sample afterwards.
          if (!w_last_sample) r_index <= r_index + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign timeout_o         = r_timeout;
  assign sample_index_o    = r_index;
  assign mem_address_o     = r_index[ADDR_W-1:0];
  assign mem_clken_o       = mem_chipselect_o;
  assign cmem_address_o    = r_index[ADDR_W-1:0];
  assign cmem_chipselect_o = mem_chipselect_o;
  assign cmem_clken_o      = mem_chipselect_o;
  assign eval_in_o         = r_sample;
  assign error_sum_o       = r_err;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// tb_chrom_eval_sequencer
//
// Directed bench for chrom_eval_sequencer with small parameters: 2-bit counters
// so that saturation is reachable, a 4-word RAM so that the run-length clamp is
// reachable, and TIMEOUT=16. The bench provides a registered RAM model and a
// circuit model that returns eval_in[7:0], after 2 cycles or in the same cycle.
module tb_chrom_eval_sequencer;

  localparam int NUM_OUT = 8;
  localparam int ERR_W   = 2;
  localparam int ADDR_W  = 2;
  localparam int MEM_LAT = 1;
  localparam int TIMEOUT = 16;

  logic                     clk_clk = 1'b0;
  logic                     reset_reset_n = 1'b0;
  logic                     start_i = 1'b0;
  logic [31:0]              seq_count_i = '0;
  logic [NUM_OUT-1:0]       valid_mask_i = '0;
  logic                     done_ack_i = 1'b0;
  logic                     ready_o, done_o, timeout_o;
  logic [31:0]              sample_index_o;
  logic [ADDR_W-1:0]        mem_address_o, cmem_address_o;
  logic                     mem_chipselect_o, mem_clken_o;
  logic                     cmem_chipselect_o, cmem_clken_o;
  logic [31:0]              mem_readdata_i = '0;
  logic [31:0]              cmem_readdata_i = '0;
  logic [31:0]              eval_in_o;
  logic                     eval_in_valid_o;
  logic [NUM_OUT-1:0]       eval_out_i;
  logic                     eval_out_valid_i;
  logic [NUM_OUT*ERR_W-1:0] error_sum_o;
  logic [2:0]               dbg_state_o;

  // ---------------- clock / reset ----------------
  always #5 clk_clk = ~clk_clk;

  chrom_eval_sequencer #(
    .NUM_OUT(NUM_OUT), .ERR_W(ERR_W), .ADDR_W(ADDR_W),
    .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .start_i(start_i), .seq_count_i(seq_count_i), .valid_mask_i(valid_mask_i),
    .done_ack_i(done_ack_i), .ready_o(ready_o), .done_o(done_o),
    .timeout_o(timeout_o), .sample_index_o(sample_index_o),
    .mem_address_o(mem_address_o), .mem_chipselect_o(mem_chipselect_o),
    .mem_clken_o(mem_clken_o), .mem_readdata_i(mem_readdata_i),
    .cmem_address_o(cmem_address_o), .cmem_chipselect_o(cmem_chipselect_o),
    .cmem_clken_o(cmem_clken_o), .cmem_readdata_i(cmem_readdata_i),
    .eval_in_o(eval_in_o), .eval_in_valid_o(eval_in_valid_o),
    .eval_out_i(eval_out_i), .eval_out_valid_i(eval_out_valid_i),
    .error_sum_o(error_sum_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- RAM and circuit models ----------------
  logic [31:0] smem [4];
  logic [31:0] cmem [4];
  int          n_cs = 0;
  int          n_applies = 0;
  int          applies_base = 0;
  int          cs_base = 0;
  int          resp_limit = 0;
  bit          zero_lat = 1'b0;
  logic        resp_en;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [7:0]  p1 = '0, p2 = '0;

  assign resp_en = ((n_applies - applies_base) < resp_limit);

  always @(posedge clk_clk) begin
    if (mem_chipselect_o && mem_clken_o)   mem_readdata_i  <= smem[mem_address_o];
    if (cmem_chipselect_o && cmem_clken_o) cmem_readdata_i <= cmem[cmem_address_o];
    if (mem_chipselect_o) n_cs <= n_cs + 1;
    if (eval_in_valid_o)  n_applies <= n_applies + 1;
    v1 <= eval_in_valid_o && resp_en && !zero_lat;
    p1 <= eval_in_o[7:0];
    v2 <= v1;
    p2 <= p1;
  end

  assign eval_out_valid_i = zero_lat ? (eval_in_valid_o && resp_en) : v2;
  assign eval_out_i       = zero_lat ? eval_in_o[7:0] : p2;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] sb_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every APPLY strobe must present the next expected sample word.
  always @(negedge clk_clk) begin
    if (reset_reset_n && eval_in_valid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL apply_unexpected: got %0h expected no strobe", eval_in_o);
      end else begin
        sb_e = exp_q.pop_front();
        if (eval_in_o !== sb_e) begin
          bad++;
          $display("FAIL apply_word: got %0h expected %0h", eval_in_o, sb_e);
        end
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] seq;
    logic [7:0]  mask;
    logic [31:0] flip;        // byte i = expected-bit inversion for sample i
    bit          zl;          // circuit answers in the APPLY cycle
    int          rl;          // circuit answers only the first rl strobes
    logic [15:0] exp_err;
    logic [31:0] exp_idx;
    logic        exp_to;
    int          exp_ap;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] seq, input logic [7:0] mask,
                              input logic [31:0] flip, input bit zl, input int rl,
                              input logic [15:0] e, input logic [31:0] idx,
                              input logic to, input int ap);
    vec_t v;
    v.seq = seq; v.mask = mask; v.flip = flip; v.zl = zl; v.rl = rl;
    v.exp_err = e; v.exp_idx = idx; v.exp_to = to; v.exp_ap = ap;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_run(input vec_t v, input int k);
    for (int i = 0; i < 4; i++) begin
      smem[i] = {8'hA0 + 8'(i), 8'h5C, 8'(k * 11 + 3), 8'(i * 71 + k * 37)};
      cmem[i] = {~smem[i][31:8], smem[i][7:0] ^ v.flip[i*8 +: 8]};
    end
    for (int i = 0; i < v.exp_ap; i++) exp_q.push_back(smem[i]);
    zero_lat     = v.zl;
    resp_limit   = v.rl;
    applies_base = n_applies;
    cs_base      = n_cs;
    seq_count_i  = v.seq;
    valid_mask_i = v.mask;
    start_i      = 1'b1;
  endtask

  task automatic wait_done(input int bound, output int cycles, output int apply_at,
                           output bit seen);
    cycles = 0; apply_at = -1; seen = 1'b0;
    while (!seen && cycles < bound) begin
      @(negedge clk_clk);
      cycles++;
      if (eval_in_valid_o) apply_at = cycles;
      if (done_o) seen = 1'b1;
    end
  endtask

  task automatic finish_run(input string name);
    start_i    = 1'b0;
    done_ack_i = 1'b1;
    @(negedge clk_clk);
    chk({name, "_ready_after_ack"}, 32'(ready_o), 32'd1);
    chk({name, "_done_after_ack"}, 32'(done_o), 32'd0);
    done_ack_i = 1'b0;
    @(negedge clk_clk);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int    cyc, ap_at;
    bit    seen;
    string nm;
    nm = $sformatf("v%0d", k);
    start_run(v, k);
    wait_done(600, cyc, ap_at, seen);
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (v.seq == 32'd0) chk({nm, "_done_within_3"}, 32'(cyc <= 3), 32'd1);
    // Timeout: 16 empty WAIT_OUT cycles follow the APPLY cycle.
    if (v.exp_to) chk({nm, "_timeout_latency"}, 32'(cyc - ap_at), 32'd17);
    for (int j = 0; j < NUM_OUT; j++)
      chk($sformatf("%s_err%0d", nm, j), 32'(error_sum_o[j*ERR_W +: ERR_W]),
          32'(v.exp_err[j*ERR_W +: ERR_W]));
    chk({nm, "_index"}, sample_index_o, v.exp_idx);
    chk({nm, "_timeout"}, 32'(timeout_o), 32'(v.exp_to));
    chk({nm, "_applies"}, 32'(n_applies - applies_base), 32'(v.exp_ap));
    chk({nm, "_cs_cycles"}, 32'(n_cs - cs_base), 32'(2 * v.exp_ap));
    chk({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    finish_run(nm);
  endtask

  // ---------------- test ----------------
  vec_t tbl [9];

  initial begin
    int cyc, ap_at, guard;
    bit seen;
    vec_t v;

    //          seq            mask   flip          zl rl   err      idx to ap
    tbl[0] = mk(32'd4,         8'hFF, 32'h0,        0, 99, 16'h0000, 3, 0, 4);
    tbl[1] = mk(32'd3,         8'h01, 32'h00010001, 0, 99, 16'h0002, 2, 0, 3);
    tbl[2] = mk(32'd4,         8'h0F, 32'h038011FF, 0, 99, 16'h005B, 3, 0, 4);
    tbl[3] = mk(32'd0,         8'hFF, 32'h0,        0, 99, 16'h0000, 0, 0, 0);
    tbl[4] = mk(32'h80000005,  8'h01, 32'h01010101, 0, 99, 16'h0003, 3, 0, 4);
    tbl[5] = mk(32'd2,         8'hF0, 32'h000030F0, 0, 99, 16'h5A00, 1, 0, 2);
    tbl[6] = mk(32'd1,         8'h81, 32'h0000007E, 0, 99, 16'h0000, 0, 0, 1);
    tbl[7] = mk(32'd3,         8'hFF, 32'h0,        0, 0,  16'h0000, 0, 1, 1);
    tbl[8] = mk(32'd2,         8'hFF, 32'h00000200, 1, 99, 16'h0004, 1, 0, 2);

    repeat (3) @(negedge clk_clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_err", 32'(error_sum_o), 32'd0);
    chk("rst_index", sample_index_o, 32'd0);
    chk("rst_cs", 32'(mem_chipselect_o), 32'd0);
    chk("rst_eval_in", eval_in_o, 32'd0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);

    for (int k = 0; k < 9; k++) run_vec(tbl[k], k);

    // Start pulse while busy, then done_ack_i with start_i still high.
    v = mk(32'd2, 8'hFF, 32'h00000001, 0, 99, 16'h0001, 1, 0, 2);
    start_run(v, 20);
    repeat (3) @(negedge clk_clk);
    start_i = 1'b0;
    @(negedge clk_clk);
    start_i = 1'b1;
    wait_done(600, cyc, ap_at, seen);
    chk("busy_done_seen", 32'(seen), 32'd1);
    chk("busy_applies", 32'(n_applies - applies_base), 32'd2);
    chk("busy_err", 32'(error_sum_o), 32'h0001);
    chk("busy_index", sample_index_o, 32'd1);
    done_ack_i = 1'b1;
    repeat (4) @(negedge clk_clk);
    chk("ack_start_high_done", 32'(done_o), 32'd1);
    chk("ack_start_high_ready", 32'(ready_o), 32'd0);
    chk("busy_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    finish_run("busy");
    // A second run must clear the previous error sums.
    run_vec(mk(32'd1, 8'hFF, 32'h0, 0, 99, 16'h0000, 0, 0, 1), 21);

    // Reset asserted while waiting for circuit outputs on sample 1.
    v = mk(32'd3, 8'hFF, 32'h0000000F, 0, 1, 16'h0055, 1, 0, 3);
    start_run(v, 30);
    guard = 0;
    while ((n_applies - applies_base) < 2 && guard < 200) begin
      @(negedge clk_clk);
      guard++;
    end
    chk("rst_mid_reached", 32'(guard < 200), 32'd1);
    repeat (2) @(negedge clk_clk);
    chk("pre_rst_state", 32'(dbg_state_o), 32'd4);
    chk("pre_rst_err", 32'(error_sum_o), 32'h0055);
    chk("pre_rst_index", sample_index_o, 32'd1);
    #2;
    reset_reset_n = 1'b0;
    start_i       = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_err", 32'(error_sum_o), 32'd0);
    chk("mid_rst_index", sample_index_o, 32'd0);
    chk("mid_rst_eval_in", eval_in_o, 32'd0);
    chk("mid_rst_state", 32'(dbg_state_o), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);
    chk("post_rst_no_done", 32'(done_o), 32'd0);
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1);
  end

endmodule
